// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N-to-1 multiplexer: mode encodings and select-width helper.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Width needed to index n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Auto-scan sequencer: holds each channel for DWELL enabled cycles and flags the return to channel 0.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DWELL = 4,
    parameter int SELW  = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic            start,
    output logic [SELW-1:0] scan_ch,
    output logic            wrap
);

    localparam int DCW = sel_width(DWELL);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
    localparam logic [DCW-1:0]  LAST_DW = DCW'(DWELL - 1);

    logic [SELW-1:0] scan_ch_reg, scan_ch_next;
    logic [DCW-1:0]  dwell_cnt_reg, dwell_cnt_next;
    logic            wrap_reg, wrap_next;

    function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] c);
        return (c == LAST_CH) ? '0 : c + SELW'(1);
    endfunction

    always_comb begin
        scan_ch_next   = scan_ch_reg;
        dwell_cnt_next = dwell_cnt_reg;
        wrap_next      = wrap_reg;
        if (en) begin
            if (clr) begin
                scan_ch_next   = '0;
                dwell_cnt_next = '0;
                wrap_next      = 1'b0;
            end else if (start) begin
                // The entry cycle already presents channel 0, so it counts as the first dwell cycle.
                if (DWELL == 1) begin
                    scan_ch_next   = next_ch('0);
                    dwell_cnt_next = '0;
                    wrap_next      = (LAST_CH == '0);
                end else begin
                    scan_ch_next   = '0;
                    dwell_cnt_next = DCW'(1);
                    wrap_next      = 1'b0;
                end
            end else if (dwell_cnt_reg == LAST_DW) begin
                scan_ch_next   = next_ch(scan_ch_reg);
                dwell_cnt_next = '0;
                wrap_next      = (scan_ch_reg == LAST_CH);
            end else begin
                dwell_cnt_next = dwell_cnt_reg + DCW'(1);
                wrap_next      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch_reg   <= '0;
            dwell_cnt_reg <= '0;
            wrap_reg      <= 1'b0;
        end else begin
            scan_ch_reg   <= scan_ch_next;
            dwell_cnt_reg <= dwell_cnt_next;
            wrap_reg      <= wrap_next;
        end
    end

    assign scan_ch = scan_ch_reg;
    assign wrap    = wrap_reg;

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 channel multiplexer with manual select and auto-scan modes.
// Define MUX_SCAN_PARITY_EN to add the registered even-parity output y_par.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NCH   = 4,
    parameter int  DWELL = 4,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] i,
    input  logic [SELW-1:0]      s,
    input  logic                 mode,
    input  logic                 en,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
    output logic [SELW-1:0]      ch,
`ifdef MUX_SCAN_PARITY_EN
    output logic                 y_par,
`endif
    output logic                 scan_wrap
);

    localparam int NSLOT = 1 << SELW;

    // Select slots beyond NCH read as zero so an illegal manual select yields y=0.
    logic [WIDTH-1:0] ch_data [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_ch
            if (gi < NCH) begin : g_live
                assign ch_data[gi] = i[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign ch_data[gi] = '0;
            end
        end
    endgenerate

    logic sel_legal;
    generate
        if (NCH == NSLOT) begin : g_full
            assign sel_legal = 1'b1;
        end else begin : g_partial
            assign sel_legal = (s < SELW'(NCH));
        end
    endgenerate

    logic [WIDTH-1:0] y_reg, y_next;
    logic             y_valid_reg, y_valid_next;
    logic [SELW-1:0]  ch_reg, ch_next;
    logic             scan_wrap_reg, scan_wrap_next;
    logic             mode_q_reg, mode_q_next;
    logic [SELW-1:0]  scan_ch;
    logic             ctr_wrap;
    logic             scan_clr, scan_start;

    assign scan_clr   = (mode == MODE_MANUAL);
    assign scan_start = (mode == MODE_AUTO) && (mode_q_reg == MODE_MANUAL);

    mux_scan_ctr #(
        .NCH   (NCH),
        .DWELL (DWELL),
        .SELW  (SELW)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (scan_clr),
        .start   (scan_start),
        .scan_ch (scan_ch),
        .wrap    (ctr_wrap)
    );

    always_comb begin
        y_next         = y_reg;
        ch_next        = ch_reg;
        y_valid_next   = 1'b0;
        scan_wrap_next = 1'b0;
        mode_q_next    = mode_q_reg;
        if (en) begin
            mode_q_next = mode;
            if (mode == MODE_MANUAL) begin
                y_next       = sel_legal ? ch_data[s] : '0;
                ch_next      = s;
                y_valid_next = sel_legal;
            end else if (mode_q_reg == MODE_MANUAL) begin
                y_next       = ch_data[0];
                ch_next      = '0;
                y_valid_next = 1'b1;
            end else begin
                y_next         = ch_data[scan_ch];
                ch_next        = scan_ch;
                y_valid_next   = 1'b1;
                scan_wrap_next = ctr_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= '0;
            y_valid_reg   <= 1'b0;
            ch_reg        <= '0;
            scan_wrap_reg <= 1'b0;
            mode_q_reg    <= MODE_MANUAL;
        end else begin
            y_reg         <= y_next;
            y_valid_reg   <= y_valid_next;
            ch_reg        <= ch_next;
            scan_wrap_reg <= scan_wrap_next;
            mode_q_reg    <= mode_q_next;
        end
    end

    assign y         = y_reg;
    assign y_valid   = y_valid_reg;
    assign ch        = ch_reg;
    assign scan_wrap = scan_wrap_reg;

`ifdef MUX_SCAN_PARITY_EN
    // y_next already holds when disabled, so its parity tracks the held value too.
    logic y_par_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_par_reg <= 1'b0;
        else        y_par_reg <= ^y_next;
    end
    assign y_par = y_par_reg;
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Scoreboard bench for mux_scan_nto1: 4-channel DWELL=2 instance plus a 3-channel DWELL=1 instance.
module tb_mux_scan_nto1;

    localparam int WA = 4, NA = 4, DA = 2;

    typedef struct packed {
        logic [3:0] y;
        logic       v;
        logic [1:0] ch;
        logic       w;
    } exp_a_t;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
        logic [1:0] ch;
        logic       w;
        logic       par;
    } exp_b_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [15:0] i_a = 16'hA5C3;
    logic [1:0]  s_a = '0;
    logic        mode_a = 1'b0, en_a = 1'b0;
    logic [3:0]  y_a;
    logic        yv_a, sw_a;
    logic [1:0]  ch_a;

    logic [23:0] i_b = {8'h5A, 8'h07, 8'h03};
    logic [1:0]  s_b = '0;
    logic        mode_b = 1'b0, en_b = 1'b0;
    logic [7:0]  y_b;
    logic        yv_b, sw_b, par_b;
    logic [1:0]  ch_b;

    int n_tests = 0;
    int n_fail  = 0;

    exp_a_t q_a[$];
    exp_b_t q_b[$];

    // Position-based reference: presentation n of a scan shows channel (n/DWELL)%NCH.
    logic       m_mode_q = 1'b0;
    int         m_k = 0;
    logic [3:0] m_y = '0;
    logic [1:0] m_ch = '0;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.WIDTH(WA), .NCH(NA), .DWELL(DA)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i_a),
        .s         (s_a),
        .mode      (mode_a),
        .en        (en_a),
        .y         (y_a),
        .y_valid   (yv_a),
        .ch        (ch_a),
`ifdef MUX_SCAN_PARITY_EN
        .y_par     (),
`endif
        .scan_wrap (sw_a)
    );

    mux_scan_nto1 #(.WIDTH(8), .NCH(3), .DWELL(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i_b),
        .s         (s_b),
        .mode      (mode_b),
        .en        (en_b),
        .y         (y_b),
        .y_valid   (yv_b),
        .ch        (ch_b),
`ifdef MUX_SCAN_PARITY_EN
        .y_par     (par_b),
`endif
        .scan_wrap (sw_b)
    );

`ifndef MUX_SCAN_PARITY_EN
    assign par_b = 1'b0;
`endif

    function automatic logic [3:0] chan_a(input int k);
        return i_a[k*WA +: WA];
    endfunction

    // Drives one cycle of stimulus on dut_a and queues the result it must show after the next edge.
    task automatic drive_a(input logic en, input logic mode, input logic [1:0] s);
        exp_a_t e;
        int n;
        en_a = en; mode_a = mode; s_a = s;
        if (!en) begin
            e.y = m_y; e.v = 1'b0; e.ch = m_ch; e.w = 1'b0;
        end else if (!mode) begin
            e.y = chan_a(int'(s)); e.v = 1'b1; e.ch = s; e.w = 1'b0;
            m_k = 0;
        end else begin
            if (!m_mode_q) m_k = 0;
            n = m_k;
            e.ch = 2'((n / DA) % NA);
            e.y  = chan_a(int'(e.ch));
            e.v  = 1'b1;
            e.w  = (n > 0) && (n % (DA * NA) == 0);
            m_k++;
        end
        if (en) m_mode_q = mode;
        m_y = e.y; m_ch = e.ch;
        q_a.push_back(e);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({y_a, yv_a, ch_a, sw_a, y_b, yv_b, ch_b, sw_b, par_b} !== '0) begin
            n_fail++;
            $display("FAIL reset: a y=%h v=%b ch=%0d w=%b b y=%h v=%b ch=%0d w=%b p=%b, required all zero",
                     y_a, yv_a, ch_a, sw_a, y_b, yv_b, ch_b, sw_b, par_b);
        end else $display("[TB] reset: outputs zero");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_manual;
        logic [1:0] sel [3] = '{2'd2, 2'd3, 2'd0};
        logic [3:0] want [3] = '{4'h5, 4'hA, 4'h3};
        exp_a_t e;
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 1'b0, sel[k]);
            @(posedge clk); #1;
            e = q_a.pop_front();
            n_tests++;
            if ({y_a, yv_a, ch_a, sw_a} !== e || y_a !== want[k]) begin
                n_fail++;
                $display("FAIL manual s=%0d: y=%h v=%b ch=%0d w=%b, required y=%h v=%b ch=%0d w=%b",
                         sel[k], y_a, yv_a, ch_a, sw_a, e.y, e.v, e.ch, e.w);
            end else $display("[TB] manual s=%0d y=%h ch=%0d", sel[k], y_a, ch_a);
        end
    endtask

    task automatic test_auto;
        logic [3:0] seq [10] = '{4'h3, 4'h3, 4'hC, 4'hC, 4'h5, 4'h5, 4'hA, 4'hA, 4'h3, 4'h3};
        exp_a_t e;
        for (int k = 0; k < 10; k++) begin
            drive_a(1'b1, 1'b1, 2'd0);
            @(posedge clk); #1;
            e = q_a.pop_front();
            n_tests++;
            if ({y_a, yv_a, ch_a, sw_a} !== e || y_a !== seq[k] || sw_a !== (k == 8)) begin
                n_fail++;
                $display("FAIL auto cycle %0d: y=%h v=%b ch=%0d w=%b, required y=%h v=%b ch=%0d w=%b",
                         k, y_a, yv_a, ch_a, sw_a, seq[k], e.v, e.ch, (k == 8));
            end else $display("[TB] auto cycle %0d y=%h ch=%0d wrap=%b", k, y_a, ch_a, sw_a);
        end
    endtask

    task automatic test_enable_hold;
        logic en_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_a_t e;
        for (int k = 0; k < 6; k++) begin
            drive_a(en_seq[k], 1'b1, 2'd0);
            @(posedge clk); #1;
            e = q_a.pop_front();
            n_tests++;
            if ({y_a, yv_a, ch_a, sw_a} !== e) begin
                n_fail++;
                $display("FAIL en_hold step %0d en=%b: y=%h v=%b ch=%0d w=%b, required y=%h v=%b ch=%0d w=%b",
                         k, en_seq[k], y_a, yv_a, ch_a, sw_a, e.y, e.v, e.ch, e.w);
            end else $display("[TB] en_hold step %0d en=%b y=%h v=%b", k, en_seq[k], y_a, yv_a);
        end
    endtask

    task automatic test_reset_mid_scan;
        exp_a_t e;
        rst_n = 1'b0;
        #1;
        m_mode_q = 1'b0; m_k = 0; m_y = '0; m_ch = '0;
        n_tests++;
        if ({y_a, yv_a, ch_a, sw_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: y=%h v=%b ch=%0d w=%b, required all zero", y_a, yv_a, ch_a, sw_a);
        end else $display("[TB] reset_mid: outputs zero immediately");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 1'b1, 2'd0);
            @(posedge clk); #1;
            e = q_a.pop_front();
            n_tests++;
            if ({y_a, yv_a, ch_a, sw_a} !== e) begin
                n_fail++;
                $display("FAIL restart cycle %0d: y=%h v=%b ch=%0d w=%b, required y=%h v=%b ch=%0d w=%b",
                         k, y_a, yv_a, ch_a, sw_a, e.y, e.v, e.ch, e.w);
            end else $display("[TB] restart cycle %0d y=%h ch=%0d", k, y_a, ch_a);
        end
    endtask

    task automatic test_back_to_back;
        // Mid-dwell on C, one manual cycle, then re-entry must restart at channel 0.
        logic       md [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] sl [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        exp_a_t e;
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b1, md[k], sl[k]);
            @(posedge clk); #1;
            e = q_a.pop_front();
            n_tests++;
            if ({y_a, yv_a, ch_a, sw_a} !== e) begin
                n_fail++;
                $display("FAIL b2b step %0d mode=%b: y=%h v=%b ch=%0d w=%b, required y=%h v=%b ch=%0d w=%b",
                         k, md[k], y_a, yv_a, ch_a, sw_a, e.y, e.v, e.ch, e.w);
            end else $display("[TB] b2b step %0d mode=%b y=%h ch=%0d", k, md[k], y_a, ch_a);
        end
    endtask

    task automatic test_nch3_dwell1;
        logic       md [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] sl [8] = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_b_t tbl [8] = '{
            '{8'h00, 1'b0, 2'd3, 1'b0, 1'b0},
            '{8'h07, 1'b1, 2'd1, 1'b0, 1'b1},
            '{8'h03, 1'b1, 2'd0, 1'b0, 1'b0},
            '{8'h03, 1'b1, 2'd0, 1'b0, 1'b0},
            '{8'h07, 1'b1, 2'd1, 1'b0, 1'b1},
            '{8'h5A, 1'b1, 2'd2, 1'b0, 1'b0},
            '{8'h03, 1'b1, 2'd0, 1'b1, 1'b0},
            '{8'h07, 1'b1, 2'd1, 1'b0, 1'b1}
        };
        exp_b_t e;
        logic par_want;
        for (int k = 0; k < 8; k++) begin
            en_b = 1'b1; mode_b = md[k]; s_b = sl[k];
            q_b.push_back(tbl[k]);
            @(posedge clk); #1;
            e = q_b.pop_front();
`ifdef MUX_SCAN_PARITY_EN
            par_want = e.par;
`else
            par_want = 1'b0;
`endif
            n_tests++;
            if ({y_b, yv_b, ch_b, sw_b} !== {e.y, e.v, e.ch, e.w} || par_b !== par_want) begin
                n_fail++;
                $display("FAIL nch3 step %0d: y=%h v=%b ch=%0d w=%b p=%b, required y=%h v=%b ch=%0d w=%b p=%b",
                         k, y_b, yv_b, ch_b, sw_b, par_b, e.y, e.v, e.ch, e.w, par_want);
            end else $display("[TB] nch3 step %0d y=%h v=%b ch=%0d w=%b p=%b", k, y_b, yv_b, ch_b, sw_b, par_b);
        end
        en_b = 1'b0;
    endtask

    initial begin
        test_reset;
        test_manual;
        test_auto;
        test_enable_hold;
        test_reset_mid_scan;
        test_back_to_back;
        test_nch3_dwell1;
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N-to-1 multiplexer of WIDTH-bit channels.
- Successor to the team's combinational gate-level 4:1 mux.
- Two modes:
  - manual: external select, one-cycle latency.
  - auto-scan: an internal counter rotates through all channels, holding each for DWELL cycles.
- Used as a time-division channel sampler in front of shared downstream logic, for example a serialiser or a monitor.

Parameters:
- WIDTH, 8: bits per channel.
- NCH, 4: number of input channels. Must be >= 1.
- DWELL, 4: cycles each channel is held in auto-scan. Must be >= 1.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i  input  NCH*WIDTH  packed channels; channel k is i[k*WIDTH +: WIDTH].
- s  input  SELW  manual select. SELW = max(1, $clog2(NCH)).
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  clock enable for the whole block.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  y holds a legal channel's data this cycle.
- ch  output  SELW  index of the channel currently on y.
- scan_wrap  output  1  one-cycle pulse when auto-scan returns to channel 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: y=0, y_valid=0, ch=0, scan_wrap=0.
  - Internal: scan_ch=0, dwell_cnt=0, mode_q=0.
  - Deassertion is used synchronously; the first update happens on the first rising edge with rst_n high.
- en=0: y, ch, scan_ch, dwell_cnt and mode_q hold their values; y_valid<=0; scan_wrap<=0.
- Manual (en=1, mode=0), latency 1 cycle:
  - y<=channel s; ch<=s; y_valid<=1; scan_wrap<=0.
  - If s>=NCH (non-power-of-2 NCH): y<=0, ch<=s, y_valid<=0.
  - scan_ch and dwell_cnt are cleared to 0.
- Entering auto (en=1, mode=1, mode_q=0):
  - y<=channel 0; ch<=0; y_valid<=1.
  - scan_ch<=0 and dwell_cnt<=1, or, if DWELL==1, an immediate advance to channel 1.
  - scan_wrap<=0.
- Auto-scan (en=1, mode=1, mode_q=1):
  - y<=channel scan_ch; ch<=scan_ch; y_valid<=1.
  - dwell_cnt increments. When dwell_cnt==DWELL-1: dwell_cnt<=0 and scan_ch advances, wrapping from NCH-1 to 0.
  - scan_wrap<=1 on the cycle y first presents channel 0 after a wrap. It is never asserted on auto entry.
- mode_q<=mode whenever en=1.
- Resulting auto sequence: every channel is output for exactly DWELL consecutive enabled cycles.
- Boundary cases:
  - NCH=1: y is always channel 0. scan_wrap pulses once every DWELL enabled cycles after entry.
  - DWELL=1: channel advances every enabled cycle.
  - Switching auto→manual mid-dwell: takes effect on the next edge. Scan state is discarded; re-entry starts at channel 0.
  - Input data i is sampled each edge, so a change to the live channel appears on y one cycle later.
  - rst_n asserted mid-scan: immediate return to the reset values above.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined: adds output y_par (1 bit), the registered even-parity bit (XOR-reduce) of the value loaded into y. It updates on the same edge as y, holds when en=0, and resets to 0.
- Undefined: port y_par and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - function sel_width(n) returning max(1, clog2(n));
  - localparam MODE_MANUAL=1'b0 and MODE_AUTO=1'b1.
- Sub-module mux_scan_ctr:
  - holds the dwell counter and scan_ch;
  - inputs: clk, rst_n, en, clr, start;
  - outputs: scan_ch, wrap.
  - The top instantiates it and performs the channel select and output registers.

Test Plan:
- Bench parameters unless stated: WIDTH=4, NCH=4, DWELL=2, i=16'hA5C3 (channel 0=3, 1=C, 2=5, 3=A).
- Manual: en=1, mode=0, s=2 → next cycle y=4'h5, ch=2, y_valid=1. Then s=3 → y=4'hA one cycle later.
- Auto: mode 0→1 held 10 cycles → y sequence 3,3,C,C,5,5,A,A,3,3. scan_wrap=1 only on the 9th cycle (first repeat of 3).
- en=0 for 3 cycles mid-scan on channel C → y stays C with y_valid=0. After en=1 returns, the second C cycle then 5,5 follow.
- NCH=3, manual s=3 → y=0, y_valid=0, ch=3. Then s=1 → y_valid=1.
- rst_n pulsed low mid-auto on channel 5 → y=0, y_valid=0, ch=0 immediately. After release with mode=1, the sequence restarts 3,3,C...
- MUX_SCAN_PARITY_EN defined, WIDTH=8, manual channel value 8'h07 → y_par=1. Value 8'h03 → y_par=0.
